// File: rtl/seq_pattern_gen_if.sv
// Handshake and serial-output bundle for seq_pattern_gen.
// start/pattern/reps are sampled on a posedge where start && ready; all outputs are registered.
interface seq_pattern_gen_if #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 4
) ();
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] reps;
    logic             ready;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, reps,
        input  ready, out, out_valid, busy, done
    );

    modport slave (
        input  start, pattern, reps,
        output ready, out, out_valid, busy, done
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a captured pattern MSB-first, repeated
// reps times with GAP idle cycles between repetitions.
module seq_pattern_gen #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 4,
    parameter int GAP   = 0
) (
    input  logic                 clk,
    input  logic                 R_n,
    seq_pattern_gen_if.slave     bus,
    output logic [1:0]           o_state
);
    localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BW-1:0] MSB_IDX  = BW'(PAT_W - 1);
    localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           r_state,   w_state;
    logic [PAT_W-1:0] r_pattern, w_pattern;
    logic [CNT_W-1:0] r_rep_cnt, w_rep_cnt;
    logic [BW-1:0]    r_bit_idx, w_bit_idx;
    logic [GW-1:0]    r_gap_cnt, w_gap_cnt;
    logic             r_out,       w_out;
    logic             r_out_valid, w_out_valid;
    logic             r_busy,      w_busy;
    logic             r_done,      w_done;
    logic             r_ready,     w_ready;
    logic [CNT_W-1:0] w_rep_left;

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            r_state     <= S_IDLE;
            r_pattern   <= '0;
            r_rep_cnt   <= '0;
            r_bit_idx   <= '0;
            r_gap_cnt   <= '0;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            r_state     <= w_state;
            r_pattern   <= w_pattern;
            r_rep_cnt   <= w_rep_cnt;
            r_bit_idx   <= w_bit_idx;
            r_gap_cnt   <= w_gap_cnt;
            r_out       <= w_out;
            r_out_valid <= w_out_valid;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_ready     <= w_ready;
        end
    end

    // Outputs are computed one edge ahead so every port comes straight from a flop.
    always_comb begin
        w_state     = r_state;
        w_pattern   = r_pattern;
        w_rep_cnt   = r_rep_cnt;
        w_bit_idx   = r_bit_idx;
        w_gap_cnt   = r_gap_cnt;
        w_out       = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_ready     = 1'b0;
        w_rep_left  = r_rep_cnt - CNT_W'(1);

        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.start && r_ready) begin
                    if (bus.reps != '0) begin
                        w_state     = S_SHIFT;
                        w_pattern   = bus.pattern;
                        w_rep_cnt   = bus.reps;
                        w_bit_idx   = MSB_IDX;
                        w_out       = bus.pattern[PAT_W-1];
                        w_out_valid = 1'b1;
                        w_busy      = 1'b1;
                        w_ready     = 1'b0;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end

            S_SHIFT: begin
                w_busy = 1'b1;
                if (r_bit_idx != '0) begin
                    w_bit_idx   = r_bit_idx - BW'(1);
                    w_out       = r_pattern[w_bit_idx];
                    w_out_valid = 1'b1;
                end else begin
                    w_rep_cnt = w_rep_left;
                    if (w_rep_left == '0) begin
                        w_state = S_IDLE;
                        w_busy  = 1'b0;
                        w_ready = 1'b1;
                        w_done  = 1'b1;
                    end else if (GAP == 0) begin
                        w_bit_idx   = MSB_IDX;
                        w_out       = r_pattern[PAT_W-1];
                        w_out_valid = 1'b1;
                    end else begin
                        w_state   = S_GAP;
                        w_gap_cnt = GAP_LOAD;
                    end
                end
            end

            S_GAP: begin
                w_busy = 1'b1;
                if (r_gap_cnt == '0) begin
                    w_state     = S_SHIFT;
                    w_bit_idx   = MSB_IDX;
                    w_out       = r_pattern[PAT_W-1];
                    w_out_valid = 1'b1;
                end else begin
                    w_gap_cnt = r_gap_cnt - GW'(1);
                end
            end

            default: begin
                w_state   = S_IDLE;
                w_ready   = 1'b1;
                w_rep_cnt = '0;
                w_bit_idx = '0;
                w_gap_cnt = '0;
            end
        endcase
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.ready     = r_ready;
    assign o_state       = r_state;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Randomised bench for seq_pattern_gen: two instances (GAP=0 and GAP=2) checked
// cycle by cycle against an expected stream built from frame arithmetic.
module tb_seq_pattern_gen;
  localparam int PAT_W = 3;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic R_n = 1'b0;
  logic [1:0] st0, st2;

  seq_pattern_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus0 ();
  seq_pattern_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus2 ();

  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP(0)) dut0 (
    .clk(clk), .R_n(R_n), .bus(bus0), .o_state(st0)
  );
  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP(2)) dut2 (
    .clk(clk), .R_n(R_n), .bus(bus2), .o_state(st2)
  );

  always #5 clk = ~clk;

  // Observation vector: {ready, busy, done, out_valid, out}
  localparam logic [4:0] IDLE_V = 5'b10000;
  localparam logic [4:0] DONE_V = 5'b10100;

  int total = 0;
  int bad = 0;
  int sel = 0;
  int hits = 0;
  int nvalid = 0;
  logic [2:0] hist = '0;
  logic [4:0] exp_q[$];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [4:0] obs();
    if (sel == 0) return {bus0.ready, bus0.busy, bus0.done, bus0.out_valid, bus0.out};
    return {bus2.ready, bus2.busy, bus2.done, bus2.out_valid, bus2.out};
  endfunction

  task automatic drive(input logic st, input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] r);
    if (sel == 0) begin
      bus0.start = st; bus0.pattern = p; bus0.reps = r;
      bus2.start = 1'b0;
    end else begin
      bus2.start = st; bus2.pattern = p; bus2.reps = r;
      bus0.start = 1'b0;
    end
  endtask

  // Expected stream for one frame: reps*PAT_W bit slots interleaved with gaps, then done.
  task automatic build_frame(input logic [PAT_W-1:0] p, input int reps);
    int period, len, pos;
    period = PAT_W + sel;
    if (reps == 0) begin
      exp_q.push_back(DONE_V);
    end else begin
      len = reps * PAT_W + (reps - 1) * sel;
      for (int c = 0; c < len; c++) begin
        pos = c % period;
        if (pos < PAT_W) exp_q.push_back({3'b010, 1'b1, p[PAT_W-1-pos]});
        else             exp_q.push_back(5'b01000);
      end
      exp_q.push_back(DONE_V);
    end
  endtask

  task automatic track_hits(input logic [4:0] v);
    if (v[1]) begin
      hist = {hist[1:0], v[0]};
      nvalid++;
      if (nvalid >= 3 && hist == 3'b101) hits++;
    end
  endtask

  // Called at a negedge with the selected DUT idle; consumes the expected stream.
  task automatic run_frame(input int tno, input logic [PAT_W-1:0] p, input int reps, input bit noise);
    logic [4:0] v, e;
    int n;
    build_frame(p, reps);
    drive(1'b1, p, CNT_W'(reps));
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      v = obs();
      check($sformatf("t%0d_c%0d", tno, n), {3'b0, v}, {3'b0, e});
      track_hits(v);
      if (exp_q.size() == 0 || !noise) drive(1'b0, p, CNT_W'(reps));
      else drive(1'($urandom_range(0, 1)), PAT_W'($urandom), CNT_W'($urandom));
      n++;
    end
  endtask

  initial begin
    logic [4:0] v, e;
    int n;
    bus0.start = 1'b0; bus0.pattern = '0; bus0.reps = '0;
    bus2.start = 1'b0; bus2.pattern = '0; bus2.reps = '0;

    #12;
    sel = 0; check("rst0", {3'b0, obs()}, {3'b0, IDLE_V});
    sel = 2; check("rst2", {3'b0, obs()}, {3'b0, IDLE_V});
    check("rst_state", {6'b0, st0}, 8'd0);
    @(negedge clk);
    R_n = 1'b1;
    @(negedge clk);

    // single 101 frame, then three contiguous repetitions
    sel = 0;
    run_frame(2, 3'b101, 1, 1'b0);
    hits = 0; nvalid = 0; hist = '0;
    run_frame(3, 3'b101, 3, 1'b0);
    check("hits_t3", 8'(hits), 8'd3);

    // gapped repetitions
    sel = 2;
    run_frame(4, 3'b110, 2, 1'b0);

    // zero repetitions on both instances
    sel = 0; run_frame(5, 3'b111, 0, 1'b0);
    sel = 2; run_frame(5, 3'b111, 0, 1'b0);

    // start held high: re-accepted in the done cycle
    sel = 0;
    hits = 0; nvalid = 0; hist = '0;
    build_frame(3'b101, 1);
    build_frame(3'b101, 1);
    drive(1'b1, 3'b101, 4'd1);
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      v = obs();
      check($sformatf("t6_c%0d", n), {3'b0, v}, {3'b0, e});
      track_hits(v);
      if (n >= 4) drive(1'b0, 3'b101, 4'd1);
      n++;
    end
    check("hits_t6", 8'(hits), 8'd2);

    // asynchronous reset mid-frame, observed between clock edges
    sel = 0;
    drive(1'b1, 3'b101, 4'd3);
    @(negedge clk);
    drive(1'b0, 3'b101, 4'd3);
    @(negedge clk);
    check("pre_rst_busy", {7'b0, bus0.busy}, 8'd1);
    @(posedge clk);
    #2 R_n = 1'b0;
    #1;
    check("async_rst", {3'b0, obs()}, {3'b0, IDLE_V});
    check("async_rst_state", {6'b0, st0}, 8'd0);
    @(negedge clk);
    R_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {3'b0, obs()}, {3'b0, IDLE_V});

    // randomised frames with input noise while busy
    for (int k = 0; k < 24; k++) begin
      sel = ($urandom_range(0, 1) == 0) ? 0 : 2;
      run_frame(100 + k, PAT_W'($urandom), int'($urandom_range(0, 5)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
